// File: rtl/player_1_ctl_pkg.sv
// Internal types for the player-1 movement controller.
`default_nettype none
package player_1_ctl_pkg;
  localparam int unsigned ANIM_CNT_W = 8;
  localparam int unsigned XPOS_W     = 12;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_R    = 2'd1,
    DIR_L    = 2'd2
  } dir_e;
endpackage
`default_nettype wire

// File: rtl/state_pkg.sv
// Player draw states shared by the movement controllers and draw stages.
`default_nettype none
package state_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RIGHT1 = 3'd1,
    RIGHT2 = 3'd2,
    LEFT1  = 3'd3,
    LEFT2  = 3'd4
  } State;
endpackage
`default_nettype wire

// File: rtl/vga_pkg.sv
// Screen geometry and sprite-size constants for the VGA display path.
`default_nettype none
package vga_pkg;
  localparam int unsigned HOR_PIXELS   = 1024;
  localparam int unsigned VER_PIXELS   = 768;
  localparam int unsigned PLAYER_WIDTH = 40;
  localparam int unsigned PLAYER_X_MAX = HOR_PIXELS - PLAYER_WIDTH;
endpackage
`default_nettype wire

// File: rtl/vblnk_tick.sv
// Rising-edge detector on vblnk, producing one frame tick per vertical blank.
`default_nettype none
module vblnk_tick (
  input  logic clk,
  input  logic rst,
  input  logic vblnk_i,
  output logic tick_o
);
  logic vblnk_q;

  // Resetting to 1 prevents a tick when vblnk is already high at reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vblnk_q <= 1'b1;
    else      vblnk_q <= vblnk_i;
  end

  assign tick_o = vblnk_i & ~vblnk_q;
endmodule
`default_nettype wire

// File: rtl/player_1_ctl.sv
// Player-1 movement and walking-animation controller, updated once per frame.
`default_nettype none
module player_1_ctl
  import state_pkg::*;
  import player_1_ctl_pkg::*;
#(
  parameter int unsigned X_MIN       = 0,
  parameter int unsigned X_MAX       = vga_pkg::PLAYER_X_MAX,
  parameter int unsigned X_INIT      = 0,
  parameter int unsigned STEP        = 4,
  parameter int unsigned ANIM_FRAMES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vblnk,
  input  logic              enable,
  input  logic              btn_left,
  input  logic              btn_right,
  output logic [XPOS_W-1:0] xpos_player1,
  output State              state,
  output logic              moving
);
  logic                  tick;
  dir_e                  dir;
  State                  state_q, state_d;
  logic [ANIM_CNT_W-1:0] anim_q, anim_d;
  logic [XPOS_W-1:0]     xpos_q, xpos_d;
  logic                  moving_q, moving_d;
  logic [XPOS_W:0]       xpos_ext, xpos_sum;

  vblnk_tick u_vblnk_tick (
    .clk     (clk),
    .rst     (rst),
    .vblnk_i (vblnk),
    .tick_o  (tick)
  );

  always_comb begin
    dir = DIR_NONE;
    if (enable && (btn_right ^ btn_left)) dir = btn_right ? DIR_R : DIR_L;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      anim_q   <= '0;
      xpos_q   <= XPOS_W'(X_INIT);
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      anim_q   <= anim_d;
      xpos_q   <= xpos_d;
      moving_q <= moving_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    anim_d   = anim_q;
    xpos_d   = xpos_q;
    moving_d = moving_q;
    xpos_ext = {1'b0, xpos_q};
    xpos_sum = xpos_ext + (XPOS_W+1)'(STEP);

    if (tick) begin
      case (dir)
        DIR_R: begin
          xpos_d = (xpos_sum > (XPOS_W+1)'(X_MAX)) ? XPOS_W'(X_MAX) : xpos_sum[XPOS_W-1:0];
          if (state_q == RIGHT1 || state_q == RIGHT2) begin
            if (anim_q == ANIM_CNT_W'(ANIM_FRAMES - 1)) begin
              state_d = (state_q == RIGHT1) ? RIGHT2 : RIGHT1;
              anim_d  = '0;
            end else begin
              anim_d = anim_q + 1'b1;
            end
          end else begin
            state_d = RIGHT1;
            anim_d  = '0;
          end
        end
        DIR_L: begin
          xpos_d = (xpos_ext < (XPOS_W+1)'(X_MIN + STEP)) ? XPOS_W'(X_MIN)
                                                           : xpos_q - XPOS_W'(STEP);
          if (state_q == LEFT1 || state_q == LEFT2) begin
            if (anim_q == ANIM_CNT_W'(ANIM_FRAMES - 1)) begin
              state_d = (state_q == LEFT1) ? LEFT2 : LEFT1;
              anim_d  = '0;
            end else begin
              anim_d = anim_q + 1'b1;
            end
          end else begin
            state_d = LEFT1;
            anim_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
          anim_d  = '0;
        end
      endcase
      moving_d = (xpos_d != xpos_q);
    end
  end

  assign xpos_player1 = xpos_q;
  assign state        = state_q;
  assign moving       = moving_q;
endmodule
`default_nettype wire
